// File: rtl/tmiw_audio_pkg.sv
// rtl/tmiw_audio_pkg.sv - shared PCM sample type and saturation helper for the audio path
package tmiw_audio_pkg;

  localparam int PCM_W     = 16;
  localparam int CIC_ORDER = 3;

  typedef logic signed [PCM_W-1:0] pcm_t;

  localparam logic signed [31:0] PCM_MAX = 32'sd32767;
  localparam logic signed [31:0] PCM_MIN = -32'sd32768;

  function automatic pcm_t sat_pcm(input logic signed [31:0] v);
    if (v > PCM_MAX) begin
      return PCM_MAX[PCM_W-1:0];
    end else if (v < PCM_MIN) begin
      return PCM_MIN[PCM_W-1:0];
    end else begin
      return v[PCM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/cic3_decim_core.sv
// rtl/cic3_decim_core.sv - 3rd-order CIC decimator core, one input bit per strobe
module cic3_decim_core
  import tmiw_audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          strobe,
  input  logic                          pdm_bit,
  output logic signed [3*DECIM_LOG2+1:0] y,
  output logic                          dump_pulse
);

  localparam int W = 3*DECIM_LOG2 + 2;

  logic signed [W-1:0] x;
  logic signed [W-1:0] i1, i2, i3, i3_upd;
  logic signed [W-1:0] d1, d2, d3;
  logic signed [W-1:0] c1, c2, c3;
  logic [DECIM_LOG2-1:0] dec_cnt;

  assign x = pdm_bit ? W'(1) : {W{1'b1}};

  // Combs see I3 as it will be after this strobe's update.
  assign i3_upd = i3 + i2;
  assign c1     = i3_upd - d1;
  assign c2     = c1 - d2;
  assign c3     = c2 - d3;

  assign dump_pulse = strobe && (&dec_cnt);
  assign y          = c3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1      <= '0;
      i2      <= '0;
      i3      <= '0;
      d1      <= '0;
      d2      <= '0;
      d3      <= '0;
      dec_cnt <= '0;
    end else if (strobe) begin
      i1      <= i1 + x;
      i2      <= i2 + i1;
      i3      <= i3_upd;
      dec_cnt <= dec_cnt + 1'b1;
      if (&dec_cnt) begin
        d1 <= i3_upd;
        d2 <= c1;
        d3 <= c2;
      end
    end
  end

endmodule

// File: rtl/pdm_to_pcm_decimator.sv
// rtl/pdm_to_pcm_decimator.sv - PDM bit clock, input sync, CIC decimation and PCM valid/ready output
module pdm_to_pcm_decimator
  import tmiw_audio_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DECIM_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        pdm_in,
  output logic        pdm_clk,
  output logic [15:0] pcm,
  output logic        pcm_valid,
  input  logic        pcm_ready,
  output logic        overrun,
  input  logic        clr_overrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int W     = 3*DECIM_LOG2 + 2;
  localparam int SHIFT = 3*DECIM_LOG2 - 15;
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV/2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [1:0]          sync;
  logic                strobe;
  logic                dump;
  logic signed [W-1:0] y;
  logic signed [W-1:0] y_shifted;
  logic signed [31:0]  y_ext;
  pcm_t                pcm_next;
  pcm_t                pcm_q;
  logic                pcm_valid_q;
  logic                overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sync    <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      sync    <= {sync[0], pdm_in};
    end
  end

  // Gated by rst_n so the pin reads low during reset even though the count is 0.
  assign pdm_clk = rst_n && en && (div_cnt <= HALF_LAST);
  assign strobe  = en && (div_cnt == HALF_LAST);

  cic3_decim_core #(
    .DECIM_LOG2(DECIM_LOG2)
  ) u_cic (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe     (strobe),
    .pdm_bit    (sync[1]),
    .y          (y),
    .dump_pulse (dump)
  );

  assign y_shifted = y >>> SHIFT;
  assign y_ext     = {{(32-W){y_shifted[W-1]}}, y_shifted};
  assign pcm_next  = sat_pcm(y_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (dump) begin
        pcm_q       <= pcm_next;
        pcm_valid_q <= 1'b1;
      end else if (pcm_ready) begin
        pcm_valid_q <= 1'b0;
      end
      if (dump && pcm_valid_q && !pcm_ready) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/pdm_to_pcm_decimator.md
Name: pdm_to_pcm_decimator

Overview:
Receive side of the team's 1-bit PDM audio path. Drives the PDM bit clock, samples a 1-bit PDM stream (from our PDM modulator output or a MEMS mic) and reconstructs signed 16-bit PCM with a 3rd-order CIC decimator. Samples are presented on a valid/ready interface to downstream logic (loopback checker, display, or buffer).

Parameters:
- CLK_DIV, 4, system clocks per PDM bit period; even, >= 4.
- DECIM_LOG2, 6, log2 of decimation ratio R (R = 64 by default); legal range 5..8.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low freezes all state, with pdm_clk held low.
- pdm_in  in  1  PDM data bit; asynchronous to clk.
- pdm_clk  out  1  PDM bit clock: high for CLK_DIV/2 clocks, then low for CLK_DIV/2 clocks.
- pcm  out  16  signed PCM sample, two's complement.
- pcm_valid  out  1  pcm holds an unconsumed sample.
- pcm_ready  in  1  consumer accepts the sample when pcm_valid && pcm_ready.
- overrun  out  1  sticky; a sample was lost.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset values: pdm_clk=0, pcm=0, pcm_valid=0, overrun=0. Divider, synchronizer, integrators, combs and decimation counter are all 0.
- Clock gen: counter 0..CLK_DIV-1. pdm_clk is high while count < CLK_DIV/2. en=0 holds the counter and forces pdm_clk low.
- Input: 2-flop synchronizer on pdm_in. Bit strobe fires in the last clk of the pdm_clk high phase (count == CLK_DIV/2-1) and uses the synchronized value. Exactly one strobe per CLK_DIV clocks.
- Mapping: bit 1 -> +1, bit 0 -> -1.
- Internal width: W = 3*DECIM_LOG2+2 bits signed. Integrators wrap modulo 2^W; this is legal for CIC.
- Integrators: three cascaded stages, updated only on a strobe. I1 += x, I2 += I1, I3 += I2. All three use pre-update values, i.e. a registered cascade.
- Decimation counter: counts strobes 0..R-1. On the strobe where the counter is R-1, the dump occurs.
- Dump: three comb stages C_k = in - delay_k operate on the I3 value after this strobe's update, then the delays update. y = comb output, range [-R^3, +R^3].
- Scaling: pcm = saturate16(y >>> (3*DECIM_LOG2-15)), arithmetic shift. +R^3 saturates to 32767; -R^3 maps to -32768.
- Latency: pcm and pcm_valid are registered. They update in the clk after the dump strobe.
- Handshake:
  - The sample is held stable while pcm_valid && !pcm_ready.
  - When pcm_valid && pcm_ready in a cycle, pcm_valid clears next cycle, unless a new dump lands in that same cycle. In that case the new sample loads and pcm_valid stays 1.
- Overrun: a dump while pcm_valid=1 and pcm_ready=0 overwrites pcm with the new sample and sets overrun.
- clr_overrun: clears overrun next cycle. If clr_overrun coincides with a new overrun event, set wins.
- Settling: the first 2 output samples after reset or after en rises from reset are CIC transients. They are still emitted and flagged by nothing; consumers discard them.
- en deassert mid-frame: state is frozen, and counting resumes exactly where it stopped. The handshake (pcm_ready acceptance, clr_overrun) still operates while en=0.
- Reset mid-operation: asynchronous; all state returns to its reset values immediately.

Decomposition:
- Shared package tmiw_audio_pkg: PCM_W=16, CIC_ORDER=3, a pcm_t typedef, and a saturate-to-PCM function. Our PDM modulator/PCM generators use the same package.
- One sub-module, cic3_decim_core. Inputs: strobe, bit, DECIM_LOG2. Outputs: y and dump_pulse.
- The top level owns the clock divider, synchronizer, scaling/saturation, handshake and overrun.

Test Plan:
- All-ones input, defaults, pcm_ready=1 -> pdm_clk period 4 clks, 50% duty. pcm_valid pulses every 256 clks. From the 3rd sample onward, pcm = 32767.
- All-zeros input -> from the 3rd sample onward, pcm = -32768. With alternating 1,0 bits, pcm = 0 from the 3rd sample onward.
- Repeating pattern 1,1,1,0 (75% density) -> settled pcm = 16384 (y = R^3/2 = 131072, >>>3).
- Backpressure: pcm_ready=0 across two dumps -> the first sample is held until the second dump, then replaced by the second. overrun=1 after the second dump. Pulsing clr_overrun -> overrun=0 the next cycle.
- Accept and dump in the same cycle: pcm_ready=1 exactly on the dump cycle with pcm_valid=1 -> pcm_valid stays 1 with the new value and overrun stays 0.
- Drop en for 37 clks mid-frame -> pdm_clk is low and the output cadence shifts by exactly 37 clks with identical values. Asserting rst_n=0 mid-frame -> all outputs are 0 immediately, without waiting for a clk edge.
